ps2_line_buffer: RTL and testbench
==================================

Name: ps2_line_buffer

Overview:
Downstream of PS2_Interface. Consumes raw set-2 scancode bytes and drops break and extended sequences. Maps make codes to ASCII and assembles a line buffer with backspace editing. On Enter it commits the line to the LOGO command parser or processor, using a valid/ack handshake and a random-access read port. It also emits a per-character echo strobe for the LCD.

Parameters:
ADDR_W, 4, log2 of line capacity; DEPTH = 1<<ADDR_W characters (16).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
key_strobe  in  1  one-cycle pulse: new scancode byte on key_data
key_data  in  8  raw set-2 scancode byte
line_valid  out  1  committed line available
line_len  out  ADDR_W+1  committed line length, 0..DEPTH
line_ack  in  1  consumer done with line; honoured only while line_valid=1
rd_addr  in  ADDR_W  read index into committed line
rd_char  out  8  buffer[rd_addr], registered, 1-cycle latency
echo_strobe  out  1  one-cycle pulse when a character is appended
echo_char  out  8  ASCII of last appended char; 0x08 after a backspace
overflow  out  1  sticky: a printable char was dropped because the buffer was full

Behaviour:
- Reset (async): FSM to S_COLLECT; write pointer 0; line_valid 0; line_len 0; rd_char 0x00; echo_strobe 0; echo_char 0x00; overflow 0; buffer contents don't-care. Reset mid-line discards the partial line and any pending line.
- Bytes are examined only on cycles with key_strobe=1.
- FSM states:
  - S_COLLECT:
    - 0xF0 -> S_BREAK.
    - 0xE0 -> S_EXT.
    - 0x5A (Enter) with ptr>0: line_len<=ptr, line_valid<=1 next cycle, -> S_READY.
    - 0x5A with ptr=0: ignored.
    - 0x66 (Backspace) with ptr>0: ptr-1, echo_strobe=1, echo_char=0x08.
    - 0x66 with ptr=0: no-op, no strobe.
    - Mappable code, ptr<DEPTH: buffer[ptr]<=ascii, ptr+1, echo_strobe=1, echo_char=ascii.
    - Mappable code, ptr=DEPTH: dropped, overflow<=1.
    - Unmapped code: ignored.
  - S_BREAK: next byte discarded -> S_COLLECT.
  - S_EXT: 0xF0 -> S_EXT_BREAK; any other byte discarded -> S_COLLECT.
  - S_EXT_BREAK: next byte discarded -> S_COLLECT.
  - S_READY: all key bytes dropped. Prefixes are not tracked; the break of Enter (F0 5A) arriving here is harmless because both bytes are dropped. line_ack=1 -> line_valid<=0, ptr<=0, overflow<=0, -> S_COLLECT. A key_strobe coincident with line_ack is dropped.
- Mapping, standard set 2:
  - A-Z -> 0x41-0x5A (e.g. 1C->A, 2B->F, 23->D).
  - 0-9 -> 0x30-0x39 (45->0, 16->1, 26->3, 2E->5).
  - 0x29 -> 0x20 (space).
  - 0x4E -> 0x2D (minus).
  - 0x49 -> 0x2E (period).
  - All other codes are unmapped.
- Buffer: DEPTH x 8 registers. Write port is owned by the FSM. The read port is independent and valid in any state; contents are stable while line_valid=1.
- line_ack while line_valid=0 is ignored.
- echo_strobe is high for exactly one cycle, the cycle after the accepted byte.

Optional Feature:
PS2_LINE_SHIFT_EN.
- Defined: track shift-held state. Make 0x12/0x59 sets it; break F0 12 / F0 59 clears it. Shift codes are never stored.
  - Letters map to lowercase 0x61-0x7A when shift is not held, uppercase when held.
  - Shift+digit: 0x1E->'@', 0x16->'!'. Other shifted digits map as unshifted.
  - Shift state clears on reset and on commit.
- Undefined: shift codes are treated as unmapped, letters are always uppercase, and no shift state register exists.

Decomposition:
- Shared package/header (ps2_defs): scancode constants SC_BREAK=F0, SC_EXT=E0, SC_ENTER=5A, SC_BKSP=66, SC_LSHIFT=12, SC_RSHIFT=59; ASCII_BS=08; FSM state encodings.
- One combinational sub-module, ps2_scancode_ascii, with ports (code[7:0], shift, ascii[7:0], hit). This module is distinct from the existing mapping module, which is not reused.

Test Plan:
- Type "FD 50": 2B,F0,2B,23,F0,23,29,F0,29,2E,F0,2E,45,F0,45,5A -> line_valid=1, line_len=5; rd_addr 0..4 give 46,44,20,35,30 one cycle later; five echo strobes.
- Backspace: 23,F0,23,66,F0,66,2B,F0,2B,5A -> line_len=1, rd_char[0]=0x46; echo_char sequence 44,08,46. Backspace on empty buffer -> no echo, ptr stays 0.
- Overflow: 17 distinct letter makes then 5A -> line_len=16, overflow=1. After line_ack, overflow=0 and line_valid=0.
- Extended/ignored: E0,75,E0,F0,75 (arrow), then 5A with empty buffer -> no echo, line_valid stays 0.
- Handshake: while line_valid=1, send 1C -> dropped and buffer unchanged. Assert line_ack coincident with key_strobe 1C -> line_valid=0 and 1C dropped. Next 1C -> echo 0x41.
- Reset mid-line: type 1C,32, assert reset -> all outputs at reset values. Then 5A -> no commit.

Source files
------------

// File: rtl/ps2_defs.sv
// Shared scancode/ASCII constants and FSM state type for the PS/2 line buffer.
package ps2_defs;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam logic [7:0] ASCII_BS  = 8'h08;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_BREAK,
    S_EXT,
    S_EXT_BREAK,
    S_READY
  } ps2_state_t;

endpackage

// File: rtl/ps2_scancode_ascii.sv
// Combinational set-2 make code to ASCII map (letters, digits, space, '-', '.').
// Optional PS2_LINE_SHIFT_EN: lowercase letters unless shift held; shift+2 '@', shift+1 '!'.
module ps2_scancode_ascii (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii,
  output logic       hit
);

  logic letter;

  always_comb begin
    ascii  = '0;
    hit    = 1'b1;
    letter = 1'b0;
    case (code)
      8'h1C: begin ascii = 8'h41; letter = 1'b1; end
      8'h32: begin ascii = 8'h42; letter = 1'b1; end
      8'h21: begin ascii = 8'h43; letter = 1'b1; end
      8'h23: begin ascii = 8'h44; letter = 1'b1; end
      8'h24: begin ascii = 8'h45; letter = 1'b1; end
      8'h2B: begin ascii = 8'h46; letter = 1'b1; end
      8'h34: begin ascii = 8'h47; letter = 1'b1; end
      8'h33: begin ascii = 8'h48; letter = 1'b1; end
      8'h43: begin ascii = 8'h49; letter = 1'b1; end
      8'h3B: begin ascii = 8'h4A; letter = 1'b1; end
      8'h42: begin ascii = 8'h4B; letter = 1'b1; end
      8'h4B: begin ascii = 8'h4C; letter = 1'b1; end
      8'h3A: begin ascii = 8'h4D; letter = 1'b1; end
      8'h31: begin ascii = 8'h4E; letter = 1'b1; end
      8'h44: begin ascii = 8'h4F; letter = 1'b1; end
      8'h4D: begin ascii = 8'h50; letter = 1'b1; end
      8'h15: begin ascii = 8'h51; letter = 1'b1; end
      8'h2D: begin ascii = 8'h52; letter = 1'b1; end
      8'h1B: begin ascii = 8'h53; letter = 1'b1; end
      8'h2C: begin ascii = 8'h54; letter = 1'b1; end
      8'h3C: begin ascii = 8'h55; letter = 1'b1; end
      8'h2A: begin ascii = 8'h56; letter = 1'b1; end
      8'h1D: begin ascii = 8'h57; letter = 1'b1; end
      8'h22: begin ascii = 8'h58; letter = 1'b1; end
      8'h35: begin ascii = 8'h59; letter = 1'b1; end
      8'h1A: begin ascii = 8'h5A; letter = 1'b1; end
      8'h45: ascii = 8'h30;
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h4E: ascii = 8'h2D;
      8'h49: ascii = 8'h2E;
      default: hit = 1'b0;
    endcase
`ifdef PS2_LINE_SHIFT_EN
    if (letter && !shift) ascii = ascii | 8'h20;
    if (shift && code == 8'h1E) ascii = 8'h40;
    if (shift && code == 8'h16) ascii = 8'h21;
`endif
  end

`ifndef PS2_LINE_SHIFT_EN
  logic unused_case_inputs;
  assign unused_case_inputs = shift ^ letter;
`endif

endmodule

// File: rtl/ps2_line_buffer.sv
// PS/2 set-2 scancode line editor: filters break/extended codes, buffers ASCII
// with backspace, commits on Enter via valid/ack. Optional PS2_LINE_SHIFT_EN.
module ps2_line_buffer
  import ps2_defs::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key_strobe,
  input  logic [7:0]        key_data,
  output logic              line_valid,
  output logic [ADDR_W:0]   line_len,
  input  logic              line_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_char,
  output logic              echo_strobe,
  output logic [7:0]        echo_char,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_FULL = {1'b1, {ADDR_W{1'b0}}};

  ps2_state_t        state, state_n;
  logic [ADDR_W:0]   ptr, ptr_n;
  logic [ADDR_W:0]   len_n;
  logic              valid_n, ovf_n, echo_stb_n, wr_en;
  logic [7:0]        echo_char_n;
  logic [7:0]        buffer [DEPTH];
  logic [7:0]        map_ascii;
  logic              map_hit;
  logic              shift_q;

`ifdef PS2_LINE_SHIFT_EN
  logic shift_n;
  logic is_shift;
  assign is_shift = (key_data == SC_LSHIFT) || (key_data == SC_RSHIFT);
`else
  assign shift_q = 1'b0;
`endif

  ps2_scancode_ascii u_map (
    .code  (key_data),
    .shift (shift_q),
    .ascii (map_ascii),
    .hit   (map_hit)
  );

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    len_n       = line_len;
    valid_n     = line_valid;
    ovf_n       = overflow;
    echo_stb_n  = 1'b0;
    echo_char_n = echo_char;
    wr_en       = 1'b0;
`ifdef PS2_LINE_SHIFT_EN
    shift_n     = shift_q;
`endif
    case (state)
      S_COLLECT: if (key_strobe) begin
        if (key_data == SC_BREAK) begin
          state_n = S_BREAK;
        end else if (key_data == SC_EXT) begin
          state_n = S_EXT;
        end else if (key_data == SC_ENTER) begin
          if (ptr != '0) begin
            len_n   = ptr;
            valid_n = 1'b1;
            state_n = S_READY;
`ifdef PS2_LINE_SHIFT_EN
            shift_n = 1'b0;
`endif
          end
        end else if (key_data == SC_BKSP) begin
          if (ptr != '0) begin
            ptr_n       = ptr - 1'b1;
            echo_stb_n  = 1'b1;
            echo_char_n = ASCII_BS;
          end
`ifdef PS2_LINE_SHIFT_EN
        end else if (is_shift) begin
          shift_n = 1'b1;
`endif
        end else if (map_hit) begin
          if (ptr != PTR_FULL) begin
            wr_en       = 1'b1;
            ptr_n       = ptr + 1'b1;
            echo_stb_n  = 1'b1;
            echo_char_n = map_ascii;
          end else begin
            ovf_n = 1'b1;
          end
        end
      end
      S_BREAK: if (key_strobe) begin
        state_n = S_COLLECT;
`ifdef PS2_LINE_SHIFT_EN
        if (is_shift) shift_n = 1'b0;
`endif
      end
      S_EXT: if (key_strobe) begin
        state_n = (key_data == SC_BREAK) ? S_EXT_BREAK : S_COLLECT;
      end
      S_EXT_BREAK: if (key_strobe) begin
        state_n = S_COLLECT;
      end
      S_READY: if (line_ack) begin
        // any key byte in this cycle is dropped along with the ack
        valid_n = 1'b0;
        ptr_n   = '0;
        ovf_n   = 1'b0;
        state_n = S_COLLECT;
      end
      default: state_n = S_COLLECT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_COLLECT;
      ptr         <= '0;
      line_len    <= '0;
      line_valid  <= 1'b0;
      overflow    <= 1'b0;
      echo_strobe <= 1'b0;
      echo_char   <= '0;
      rd_char     <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      line_len    <= len_n;
      line_valid  <= valid_n;
      overflow    <= ovf_n;
      echo_strobe <= echo_stb_n;
      echo_char   <= echo_char_n;
      rd_char     <= buffer[rd_addr];
    end
  end

`ifdef PS2_LINE_SHIFT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) shift_q <= 1'b0;
    else       shift_q <= shift_n;
  end
`endif

  always_ff @(posedge clock) begin
    if (wr_en) buffer[ptr[ADDR_W-1:0]] <= map_ascii;
  end

endmodule

// File: tb/tb_ps2_line_buffer.sv
// Directed, table-driven self-checking bench for ps2_line_buffer (default build).
module tb_ps2_line_buffer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_strobe = 1'b0;
  logic [7:0] key_data = '0;
  logic       line_valid;
  logic [4:0] line_len;
  logic       line_ack = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_char;
  logic       echo_strobe;
  logic [7:0] echo_char;
  logic       overflow;

  ps2_line_buffer #(.ADDR_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .key_strobe  (key_strobe),
    .key_data    (key_data),
    .line_valid  (line_valid),
    .line_len    (line_len),
    .line_ack    (line_ack),
    .rd_addr     (rd_addr),
    .rd_char     (rd_char),
    .echo_strobe (echo_strobe),
    .echo_char   (echo_char),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] code;
    logic       exp_stb;
    logic [7:0] exp_char;
  } vec_t;

  vec_t vecs [32];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input logic [7:0] c, input logic s, input logic [7:0] ch);
    vecs[idx].code     = c;
    vecs[idx].exp_stb  = s;
    vecs[idx].exp_char = ch;
  endtask

  // Strobe one byte, return echo outputs sampled the cycle after acceptance.
  task automatic send_key(input logic [7:0] c, output logic stb, output logic [7:0] ch);
    @(negedge clock);
    key_strobe = 1'b1;
    key_data   = c;
    @(negedge clock);
    key_strobe = 1'b0;
    stb = echo_strobe;
    ch  = echo_char;
  endtask

  task automatic read_char(input logic [3:0] a, output logic [7:0] ch);
    @(negedge clock);
    rd_addr = a;
    @(negedge clock);
    ch = rd_char;
  endtask

  task automatic do_ack();
    @(negedge clock);
    line_ack = 1'b1;
    @(negedge clock);
    line_ack = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    logic       stb;
    logic [7:0] ch;
    for (int i = lo; i <= hi; i++) begin
      send_key(vecs[i].code, stb, ch);
      check($sformatf("echo_stb[%0d]", i), 32'(stb), 32'(vecs[i].exp_stb));
      if (vecs[i].exp_stb)
        check($sformatf("echo_char[%0d]", i), 32'(ch), 32'(vecs[i].exp_char));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   32'(line_valid),  32'd0);
    check({tag, "_len"},     32'(line_len),    32'd0);
    check({tag, "_rdchar"},  32'(rd_char),     32'd0);
    check({tag, "_estb"},    32'(echo_strobe), 32'd0);
    check({tag, "_echar"},   32'(echo_char),   32'd0);
    check({tag, "_ovf"},     32'(overflow),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic       stb;
    logic [7:0] ch;
    logic [7:0] letters [17];
    logic [7:0] fd50 [5];

    // "FD 50"
    set_vec(0,  8'h2B, 1, 8'h46); set_vec(1,  8'hF0, 0, 8'h00); set_vec(2,  8'h2B, 0, 8'h00);
    set_vec(3,  8'h23, 1, 8'h44); set_vec(4,  8'hF0, 0, 8'h00); set_vec(5,  8'h23, 0, 8'h00);
    set_vec(6,  8'h29, 1, 8'h20); set_vec(7,  8'hF0, 0, 8'h00); set_vec(8,  8'h29, 0, 8'h00);
    set_vec(9,  8'h2E, 1, 8'h35); set_vec(10, 8'hF0, 0, 8'h00); set_vec(11, 8'h2E, 0, 8'h00);
    set_vec(12, 8'h45, 1, 8'h30); set_vec(13, 8'hF0, 0, 8'h00); set_vec(14, 8'h45, 0, 8'h00);
    set_vec(15, 8'h5A, 0, 8'h00);
    // backspace editing
    set_vec(16, 8'h23, 1, 8'h44); set_vec(17, 8'hF0, 0, 8'h00); set_vec(18, 8'h23, 0, 8'h00);
    set_vec(19, 8'h66, 1, 8'h08); set_vec(20, 8'hF0, 0, 8'h00); set_vec(21, 8'h66, 0, 8'h00);
    set_vec(22, 8'h2B, 1, 8'h46); set_vec(23, 8'hF0, 0, 8'h00); set_vec(24, 8'h2B, 0, 8'h00);
    set_vec(25, 8'h5A, 0, 8'h00);
    // extended arrow make/break, then Enter on empty line
    set_vec(26, 8'hE0, 0, 8'h00); set_vec(27, 8'h75, 0, 8'h00); set_vec(28, 8'hE0, 0, 8'h00);
    set_vec(29, 8'hF0, 0, 8'h00); set_vec(30, 8'h75, 0, 8'h00); set_vec(31, 8'h5A, 0, 8'h00);

    letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15};
    fd50    = '{8'h46, 8'h44, 8'h20, 8'h35, 8'h30};

    repeat (2) @(negedge clock);
    check_reset_outputs("por");
    reset = 1'b0;

    run_vecs(0, 15);
    check("fd50_valid", 32'(line_valid), 32'd1);
    check("fd50_len",   32'(line_len),   32'd5);
    for (int i = 0; i < 5; i++) begin
      read_char(4'(i), ch);
      check($sformatf("fd50_rd[%0d]", i), 32'(ch), 32'(fd50[i]));
    end

    // keys while a line is pending are dropped
    send_key(8'h1C, stb, ch);
    check("ready_drop_stb", 32'(stb), 32'd0);
    read_char(4'd0, ch);
    check("ready_buf0", 32'(ch), 32'h46);
    check("ready_len", 32'(line_len), 32'd5);

    // ack coincident with a key byte
    @(negedge clock);
    key_strobe = 1'b1; key_data = 8'h1C; line_ack = 1'b1;
    @(negedge clock);
    key_strobe = 1'b0; line_ack = 1'b0;
    check("ack_valid", 32'(line_valid), 32'd0);
    check("ack_drop_stb", 32'(echo_strobe), 32'd0);

    send_key(8'h1C, stb, ch);
    check("post_ack_stb", 32'(stb), 32'd1);
    check("post_ack_char", 32'(ch), 32'h41);
    send_key(8'h66, stb, ch);
    check("bs_stb", 32'(stb), 32'd1);
    check("bs_char", 32'(ch), 32'h08);
    send_key(8'h66, stb, ch);
    check("bs_empty_stb", 32'(stb), 32'd0);
    send_key(8'h5A, stb, ch);
    check("enter_empty_stb", 32'(stb), 32'd0);
    check("enter_empty_valid", 32'(line_valid), 32'd0);

    run_vecs(16, 25);
    check("bs_line_valid", 32'(line_valid), 32'd1);
    check("bs_line_len",   32'(line_len),   32'd1);
    read_char(4'd0, ch);
    check("bs_rd0", 32'(ch), 32'h46);
    do_ack();
    check("bs_ack_valid", 32'(line_valid), 32'd0);

    run_vecs(26, 31);
    check("ext_valid", 32'(line_valid), 32'd0);

    // ack with no pending line must not clear the partial line
    send_key(8'h1C, stb, ch);
    do_ack();
    send_key(8'h5A, stb, ch);
    check("idle_ack_valid", 32'(line_valid), 32'd1);
    check("idle_ack_len",   32'(line_len),   32'd1);
    do_ack();

    // overflow: 16 accepted, 17th dropped
    for (int i = 0; i < 17; i++) begin
      send_key(letters[i], stb, ch);
      if (i < 16) begin
        check($sformatf("ovf_stb[%0d]", i), 32'(stb), 32'd1);
        check($sformatf("ovf_char[%0d]", i), 32'(ch), 32'h41 + 32'(i));
        if (i == 15) check("ovf_not_yet", 32'(overflow), 32'd0);
      end else begin
        check("ovf_drop_stb", 32'(stb), 32'd0);
      end
    end
    check("ovf_flag", 32'(overflow), 32'd1);
    send_key(8'h5A, stb, ch);
    check("ovf_valid", 32'(line_valid), 32'd1);
    check("ovf_len",   32'(line_len),   32'd16);
    read_char(4'd15, ch);
    check("ovf_rd15", 32'(ch), 32'h50);
    read_char(4'd0, ch);
    check("ovf_rd0", 32'(ch), 32'h41);
    do_ack();
    check("ovf_ack_flag",  32'(overflow),   32'd0);
    check("ovf_ack_valid", 32'(line_valid), 32'd0);

    // reset mid-line
    send_key(8'h1C, stb, ch);
    send_key(8'h32, stb, ch);
    check("pre_rst_char", 32'(ch), 32'h42);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_reset_outputs("mid");
    @(negedge clock);
    reset = 1'b0;
    send_key(8'h5A, stb, ch);
    check("rst_enter_stb", 32'(stb), 32'd0);
    check("rst_enter_valid", 32'(line_valid), 32'd0);
    send_key(8'h1C, stb, ch);
    send_key(8'h5A, stb, ch);
    check("rst_new_len", 32'(line_len), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
